hc595_chain_tx: RTL and testbench

- Parametrised serial driver for a daisy-chain of N_REG cascaded 74HC595 shift registers.
- Takes one parallel frame per valid/ready handshake and shifts it out on ds/shcp with a programmable bit rate.
- Commits the frame to the outputs with a single stcp pulse and manages oe, so outputs stay blanked until the first valid frame is latched.
- Successor to the fixed 16-bit segment-display shifter. Sits between display/IO logic (segment scanners, LED banks, relay drivers) and the board-level 595 chain.

---
 rtl/hc595_chain_tx.sv | 150 +++++++++++++++
 tb/tb_hc595_chain_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_chain_tx.sv
// Serial driver for a daisy-chain of 74HC595s: one frame per handshake,
// shifted on ds/shcp at a programmable rate and committed with one stcp pulse.
module hc595_chain_tx #(
    parameter int N_REG     = 2,
    parameter int DIV       = 2,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic [8*N_REG-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               enable,
    output logic               ds,
    output logic               shcp,
    output logic               stcp,
    output logic               oe,
    output logic               busy,
    output logic               done
);
    localparam int W  = 8 * N_REG;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(W);

    localparam logic [PW-1:0] PH_END  = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [BW-1:0] BIT_END = BW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ph_q;
    logic [BW-1:0] bit_q;
    logic [W-1:0]  sr_q;
    logic          ds_q;
    logic          shcp_q;
    logic          stcp_q;
    logic          oe_q;
    logic          busy_q;
    logic          done_q;
    logic          rdy_q;
    logic          latched_q;

    logic [W-1:0]  sr_nxt;
    logic          ph_end;

    function automatic logic head(input logic [W-1:0] v);
        return LSB_FIRST ? v[0] : v[W-1];
    endfunction

    assign sr_nxt = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    assign ph_end = (ph_q == PH_END);

    // The final stcp-low cycle doubles as the IDLE/done cycle, so a frame
    // waiting on din_valid is taken there and frames run with no gap.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            ds_q      <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            oe_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            oe_q   <= ~(enable & latched_q);
            ph_q   <= ph_end ? '0 : ph_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    ph_q   <= '0;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (din_valid && rdy_q) begin
                        sr_q    <= din;
                        ds_q    <= head(din);
                        bit_q   <= '0;
                        state_q <= SHIFT_LO;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (ph_end) begin
                        state_q <= SHIFT_HI;
                        shcp_q  <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (ph_end) begin
                        shcp_q <= 1'b0;
                        if (bit_q == BIT_END) begin
                            state_q <= LATCH_HI;
                            stcp_q  <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            sr_q    <= sr_nxt;
                            ds_q    <= head(sr_nxt);
                            state_q <= SHIFT_LO;
                        end
                    end
                end
                LATCH_HI: begin
                    if (ph_end) begin
                        stcp_q <= 1'b0;
                        if (DIV == 1) begin
                            state_q   <= IDLE;
                            done_q    <= 1'b1;
                            latched_q <= 1'b1;
                            busy_q    <= 1'b0;
                            rdy_q     <= 1'b1;
                        end else begin
                            state_q <= LATCH_LO;
                        end
                    end
                end
                LATCH_LO: begin
                    if (ph_q == PH_PRE) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        latched_q <= 1'b1;
                        busy_q    <= 1'b0;
                        rdy_q     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready = rdy_q;
    assign ds        = ds_q;
    assign shcp      = shcp_q;
    assign stcp      = stcp_q;
    assign oe        = oe_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hc595_chain_tx.sv
// Scoreboard bench for hc595_chain_tx: two instances (16-bit/DIV=2/MSB-first
// and 8-bit/DIV=1/LSB-first) driven with random frames and checked per cycle.
`timescale 1ns/1ps
module tb_hc595_chain_tx;
    localparam int LIM = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] din_s  [2];
    logic        vld_s  [2];
    logic        en_s   [2];
    logic        rdy_s  [2];
    logic        ds_s   [2];
    logic        shcp_s [2];
    logic        stcp_s [2];
    logic        oe_s   [2];
    logic        busy_s [2];
    logic        done_s [2];

    hc595_chain_tx #(.N_REG(2), .DIV(2), .LSB_FIRST(1'b0)) u_a (
        .sclk(clk), .rst(rst), .din(din_s[0]), .din_valid(vld_s[0]),
        .din_ready(rdy_s[0]), .enable(en_s[0]), .ds(ds_s[0]),
        .shcp(shcp_s[0]), .stcp(stcp_s[0]), .oe(oe_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    hc595_chain_tx #(.N_REG(1), .DIV(1), .LSB_FIRST(1'b1)) u_b (
        .sclk(clk), .rst(rst), .din(din_s[1][7:0]), .din_valid(vld_s[1]),
        .din_ready(rdy_s[1]), .enable(en_s[1]), .ds(ds_s[1]),
        .shcp(shcp_s[1]), .stcp(stcp_s[1]), .oe(oe_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    typedef struct {
        int          g;
        logic [15:0] d;
        int          acc;
    } item_t;

    item_t sbq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    last_acc [2];
    bit    gapchk   [2];
    int    nb       [2];
    int    hi_run   [2];
    int    st_run   [2];
    bit    lat      [2];
    bit    pshcp    [2];
    bit    pstcp    [2];
    bit    pds      [2];

    function automatic int wof(int g);
        return (g == 0) ? 16 : 8;
    endfunction

    function automatic int dof(int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic bit lsbof(int g);
        return g == 1;
    endfunction

    function automatic int find(int g);
        foreach (sbq[i]) if (sbq[i].g == g) return i;
        return -1;
    endfunction

    task automatic chk(int g, string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0d want=%0d t=%0t",
                     name, g, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Expected frames are pushed when the handshake fires.
    always @(posedge clk) begin
        item_t it;
        for (int g = 0; g < 2; g++) begin
            if (!rst && vld_s[g] && rdy_s[g]) begin
                it.g   = g;
                it.d   = din_s[g];
                it.acc = cyc;
                sbq.push_back(it);
                if (gapchk[g] && last_acc[g] >= 0)
                    chk(g, "accept_gap", cyc - last_acc[g],
                        2 * dof(g) * (wof(g) + 1));
                last_acc[g] = cyc;
            end
        end
    end

    task automatic mon(int g);
        int w;
        int d;
        int k;
        w = wof(g);
        d = dof(g);
        if (rst) begin
            chk(g, "reset_outputs",
                {ds_s[g], shcp_s[g], stcp_s[g], oe_s[g],
                 busy_s[g], done_s[g], rdy_s[g]}, 7'b0001000);
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].g == g) sbq.delete(i);
            nb[g] = 0; lat[g] = 0; hi_run[g] = 0; st_run[g] = 0;
            pshcp[g] = 0; pstcp[g] = 0; pds[g] = 0;
            return;
        end
        chk(g, "oe", oe_s[g], !(en_s[g] && lat[g]));
        chk(g, "ready_vs_busy", rdy_s[g], !busy_s[g]);
        k = find(g);
        if (shcp_s[g] && !pshcp[g]) begin
            chk(g, "shcp_rise_in_frame", (k >= 0 && nb[g] < w), 1);
            if (k >= 0 && nb[g] < w)
                chk(g, "ds_at_rise", ds_s[g],
                    lsbof(g) ? sbq[k].d[nb[g]] : sbq[k].d[w-1-nb[g]]);
            nb[g]++;
        end
        if (pshcp[g] && shcp_s[g]) chk(g, "ds_hold_hi", ds_s[g], pds[g]);
        if (shcp_s[g]) hi_run[g]++;
        else if (pshcp[g]) begin
            chk(g, "shcp_hi_len", hi_run[g], d);
            hi_run[g] = 0;
        end
        if (stcp_s[g]) begin
            chk(g, "stcp_with_shcp", shcp_s[g], 0);
            if (!pstcp[g]) chk(g, "bits_before_stcp", nb[g], w);
            st_run[g]++;
        end else if (pstcp[g]) begin
            chk(g, "stcp_hi_len", st_run[g], d);
            st_run[g] = 0;
        end
        if (done_s[g]) begin
            chk(g, "done_has_frame", k >= 0, 1);
            if (k >= 0) begin
                chk(g, "latency", cyc - sbq[k].acc, 2 * d * (w + 1));
                sbq.delete(k);
            end
            chk(g, "bits_at_done", nb[g], w);
            nb[g] = 0;
            lat[g] = 1;
        end
        pshcp[g] = shcp_s[g];
        pstcp[g] = stcp_s[g];
        pds[g]   = ds_s[g];
    endtask

    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) mon(g);
    end

    task automatic send(int g, logic [15:0] d);
        int t;
        t = 0;
        din_s[g] = d;
        vld_s[g] = 1'b1;
        while (!rdy_s[g] && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk(g, "ready_wait", rdy_s[g], 1);
        @(negedge clk);
        vld_s[g] = 1'b0;
        din_s[g] = 16'($urandom);
    endtask

    task automatic poke(int g);
        if (busy_s[g]) begin
            vld_s[g] = 1'b1;
            din_s[g] = 16'($urandom);
            @(negedge clk);
            vld_s[g] = 1'b0;
        end
    endtask

    task automatic wait_idle(int g);
        int t;
        t = 0;
        while (!(rdy_s[g] && !busy_s[g] && find(g) < 0) && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk(g, "idle_wait", (rdy_s[g] && find(g) < 0), 1);
    endtask

    task automatic b2b(int g, int n);
        int t;
        last_acc[g] = -1;
        gapchk[g] = 1'b1;
        din_s[g] = 16'($urandom);
        vld_s[g] = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!rdy_s[g] && t < LIM) begin
                @(negedge clk);
                t++;
            end
            chk(g, "b2b_ready", rdy_s[g], 1);
            @(negedge clk);
            din_s[g] = 16'($urandom);
        end
        vld_s[g] = 1'b0;
        gapchk[g] = 1'b0;
    endtask

    task automatic seq(int g, logic [15:0] first);
        send(g, first);
        wait_idle(g);
        b2b(g, 3);
        wait_idle(g);
        en_s[g] = 1'b0;
        repeat (4) @(negedge clk);
        en_s[g] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(g, 16'($urandom));
            if ($urandom_range(0, 1) == 1) poke(g);
            if ($urandom_range(0, 2) == 0) en_s[g] = ~en_s[g];
            if ($urandom_range(0, 1) == 1) wait_idle(g);
        end
        wait_idle(g);
        en_s[g] = 1'b1;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            vld_s[g] = 1'b0;
            din_s[g] = '0;
            en_s[g] = 1'b1;
            gapchk[g] = 1'b0;
            last_acc[g] = -1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fork
            seq(0, 16'hA5C3);
            seq(1, 16'h0081);
        join
        send(0, 16'h5A3C);
        t = 0;
        while (nb[0] < 7 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk(0, "reach_bit7", nb[0] >= 7, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(0, 16'($urandom));
        send(1, 16'($urandom));
        wait_idle(0);
        wait_idle(1);
        chk(0, "drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
